// File: rtl/latch_bank_pkg.sv
// Shared types and defaults for the latch-bank write arbiter.
package latch_bank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/latch_bank_wr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves to the other
// requester after every granted advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q;  // 0 favours requester 0 on contention

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ptr_q <= 1'b0;
    else if (advance && |gnt)   ptr_q <= gnt[0];
  end

endmodule

// File: rtl/latch_bank_wr_arbiter.sv
// Arbitrates two write requesters onto a shared latch bank, sequencing each
// write as setup / one-hot enable / hold with all outputs driven from flops.
module latch_bank_wr_arbiter
  import latch_bank_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] data0,
  output logic             done0,
  input  logic             req1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] data1,
  output logic             done1,
  output logic [WIDTH-1:0] lat_d,
  output logic [DEPTH-1:0] lat_en,
  output logic             busy,
  output logic             err
);

  localparam logic [AW:0] DEPTH_LIM = DEPTH[AW:0];

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q;
  logic             win_q;
  logic [1:0]       gnt;
  logic             capture;
  logic             in_range;
  logic [DEPTH-1:0] lat_en_d;
  logic [WIDTH-1:0] lat_d_d;
  logic             done0_d, done1_d, err_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1, req0}),
    .advance (capture),
    .gnt     (gnt)
  );

  // Non-power-of-two banks leave address codes with no latch behind them.
  assign in_range = ({1'b0, addr_q} < DEPTH_LIM);

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    lat_en_d = '0;
    lat_d_d  = lat_d;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          capture = 1'b1;
          lat_d_d = gnt[1] ? data1 : data0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        for (int i = 0; i < DEPTH; i++) lat_en_d[i] = (addr_q == AW'(i));
        state_d = ENABLE;
      end
      ENABLE: begin
        done0_d = !win_q;
        done1_d = win_q;
        err_d   = !in_range;
        state_d = HOLD;
      end
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      win_q   <= 1'b0;
      lat_en  <= '0;
      lat_d   <= '0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_en  <= lat_en_d;
      lat_d   <= lat_d_d;
      done0   <= done0_d;
      done1   <= done1_d;
      err     <= err_d;
      busy    <= (state_d != IDLE);
      if (capture) begin
        addr_q <= gnt[1] ? addr1 : addr0;
        win_q  <= gnt[1];
      end
    end
  end

endmodule

// File: tb/tb_latch_bank_wr_arbiter.sv
// Self-checking bench: transaction-level model of the arbiter (grant order,
// fixed 4-cycle write timeline, latch contents) against two DUT instances.
module tb_latch_bank_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [1:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       done0, done1, busy, err;
  logic [7:0] lat_d;
  logic [3:0] lat_en;

  logic       b_req0, b_req1;
  logic [1:0] b_addr0, b_addr1;
  logic [7:0] b_data0, b_data1;
  logic       b_done0, b_done1, b_busy, b_err;
  logic [7:0] b_lat_d;
  logic [2:0] b_lat_en;

  int vectors = 0;
  int miscompares = 0;
  bit ptr_m;
  logic [7:0] bank [4];

  always #5 clk = ~clk;

  latch_bank_wr_arbiter #(.DEPTH(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .data0(data0), .done0(done0),
    .req1(req1), .addr1(addr1), .data1(data1), .done1(done1),
    .lat_d(lat_d), .lat_en(lat_en), .busy(busy), .err(err)
  );

  latch_bank_wr_arbiter #(.DEPTH(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0(b_req0), .addr0(b_addr0), .data0(b_data0), .done0(b_done0),
    .req1(b_req1), .addr1(b_addr1), .data1(b_data1), .done1(b_done1),
    .lat_d(b_lat_d), .lat_en(b_lat_en), .busy(b_busy), .err(b_err)
  );

  // Behavioural latch bank fed by the DUT's d/en bus.
  always @(lat_en or lat_d)
    for (int i = 0; i < 4; i++) if (lat_en[i]) bank[i] = lat_d;

  function automatic logic [15:0] obs_main();
    return {busy, done0, done1, err, lat_en, lat_d};
  endfunction

  // One write on the main DUT; expected winner and timeline come from the model.
  task automatic do_write(input bit r0, input bit r1, input logic [1:0] a0,
                          input logic [1:0] a1, input logic [7:0] d0,
                          input logic [7:0] d1, input string name, output bit w);
    logic [15:0] exp;
    logic [1:0]  a;
    logic [7:0]  d;
    logic [3:0]  en;
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1; data0 = d0; data1 = d1;
    w     = (r0 && r1) ? ptr_m : r1;
    ptr_m = !w;
    a  = w ? a1 : a0;
    d  = w ? d1 : d0;
    en = 4'b0001 << a;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      case (c)
        0:       exp = {1'b1, 3'b000, 4'b0000, d};
        1:       exp = {1'b1, 3'b000, en, d};
        2:       exp = {1'b1, !w, w, 1'b0, 4'b0000, d};
        default: exp = {1'b0, 3'b000, 4'b0000, d};
      endcase
      vectors++;
      if (obs_main() !== exp) begin
        miscompares++;
        $display("FAIL %s cycle %0d: {busy,done0,done1,err,en,d} got %h expected %h",
                 name, c, obs_main(), exp);
      end
      if (c == 2) begin
        vectors++;
        if (bank[a] !== d) begin
          miscompares++;
          $display("FAIL %s latch word %0d: got %h expected %h", name, a, bank[a], d);
        end
        @(negedge clk);
        if (w) req1 = 1'b0; else req0 = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
    b_req0 = 0; b_req1 = 0; b_addr0 = 0; b_addr1 = 0; b_data0 = 0; b_data1 = 0;
    ptr_m = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (obs_main() !== 16'h0 || {b_busy, b_done0, b_done1, b_err, b_lat_en, b_lat_d} !== 15'h0) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: main %h dut3 %h required 0", c, obs_main(),
                 {b_busy, b_done0, b_done1, b_err, b_lat_en, b_lat_d});
      end
      if (c == 1) begin @(negedge clk); rst_n = 1'b1; end
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    bit w;
    do_write(1'b1, 1'b0, 2'd2, 2'd0, 8'hA5, 8'h00, "single", w);
  endtask

  task automatic test_contention();
    bit w;
    rst_n = 1'b0;
    req0 = 1; req1 = 1; addr0 = 2'd1; addr1 = 2'd3; data0 = 8'h11; data1 = 8'h33;
    ptr_m = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_write(1'b1, 1'b1, 2'd1, 2'd3, 8'h11, 8'h33, "contention_first", w);
    do_write(1'b0, 1'b1, 2'd1, 2'd3, 8'h11, 8'h33, "contention_second", w);
  endtask

  task automatic test_fairness();
    bit w;
    for (int n = 0; n < 6; n++)
      do_write(1'b1, 1'b1, 2'($urandom_range(3)), 2'($urandom_range(3)),
               8'($urandom_range(255)), 8'($urandom_range(255)), "fairness", w);
  endtask

  task automatic test_random();
    bit w, p0 = 0, p1 = 0;
    logic [1:0] pa0 = 0, pa1 = 0;
    logic [7:0] pd0 = 0, pd1 = 0;
    for (int n = 0; n < 24; n++) begin
      if (!p0 && $urandom_range(1) == 1) begin
        p0 = 1; pa0 = 2'($urandom_range(3)); pd0 = 8'($urandom_range(255));
      end
      if (!p1 && $urandom_range(1) == 1) begin
        p1 = 1; pa1 = 2'($urandom_range(3)); pd1 = 8'($urandom_range(255));
      end
      if (!p0 && !p1) begin
        p0 = 1; pa0 = 2'($urandom_range(3)); pd0 = 8'($urandom_range(255));
      end
      do_write(p0, p1, pa0, pa1, pd0, pd1, "random", w);
      if (w) p1 = 0; else p0 = 0;
    end
  endtask

  // DEPTH=3 instance: address 3 has no latch, address 2 does.
  task automatic test_out_of_range();
    logic [14:0] exp, obs;
    logic [7:0]  d;
    logic [1:0]  a;
    bit          oor;
    for (int t = 0; t < 2; t++) begin
      a   = (t == 0) ? 2'd3 : 2'd2;
      oor = (a >= 2'd3);
      d   = 8'($urandom_range(255));
      b_req1 = 1'b1; b_addr1 = a; b_data1 = d;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        case (c)
          0:       exp = {1'b1, 3'b000, 3'b000, d};
          1:       exp = {1'b1, 3'b000, oor ? 3'b000 : 3'b100, d};
          2:       exp = {1'b1, 1'b0, 1'b1, oor, 3'b000, d};
          default: exp = {1'b0, 3'b000, 3'b000, d};
        endcase
        obs = {b_busy, b_done0, b_done1, b_err, b_lat_en, b_lat_d};
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL out_of_range addr %0d cycle %0d: got %h expected %h", a, c, obs, exp);
        end
        if (c == 2) begin @(negedge clk); b_req1 = 1'b0; end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    bit w;
    logic [1:0] a;
    logic [7:0] d;
    a = 2'($urandom_range(3));
    d = 8'($urandom_range(255));
    req0 = 1'b1; req1 = 1'b0; addr0 = a; data0 = d;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (lat_en !== (4'b0001 << a)) begin
      miscompares++;
      $display("FAIL mid_reset enable: got %b expected %b", lat_en, 4'b0001 << a);
    end
    #2 rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    vectors++;
    if (obs_main() !== 16'h0) begin
      miscompares++;
      $display("FAIL mid_reset async clear: got %h expected 0000", obs_main());
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (obs_main() !== 16'h0) begin
        miscompares++;
        $display("FAIL mid_reset held cycle %0d: got %h expected 0000", c, obs_main());
      end
    end
    @(negedge clk); rst_n = 1'b1;
    ptr_m = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (obs_main() !== 16'h0) begin
      miscompares++;
      $display("FAIL mid_reset idle after release: got %h expected 0000", obs_main());
    end
    @(negedge clk);
    do_write(1'b1, 1'b1, 2'($urandom_range(3)), 2'($urandom_range(3)),
             8'($urandom_range(255)), 8'($urandom_range(255)), "mid_reset_pointer", w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_random();
    test_out_of_range();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
